// File: rtl/issue_queue_select_scheduler.sv
// Issue queue select scheduler: per-entry lifecycle (EMPTY/WAIT/ISSUED),
// round-robin selection of up to ISSUE_WIDTH ready entries, execution
// latency timing and the wakeup/release vectors returned to the dependency matrix.
module issue_queue_select_scheduler #(
    parameter int unsigned ISSUE_QUEUE_ENTRY_NUM = 16,
    parameter int unsigned DISPATCH_WIDTH        = 2,
    parameter int unsigned ISSUE_WIDTH           = 2,
    parameter int unsigned MAX_LATENCY           = 4,
    localparam int unsigned IDXW = $clog2(ISSUE_QUEUE_ENTRY_NUM),
    localparam int unsigned LW   = $clog2(MAX_LATENCY + 1),
    localparam int unsigned OCCW = $clog2(ISSUE_QUEUE_ENTRY_NUM + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall,
    input  logic                                  flush,
    input  logic [DISPATCH_WIDTH-1:0]             dispatch,
    input  logic [DISPATCH_WIDTH-1:0][IDXW-1:0]   dispatchPtr,
    input  logic [DISPATCH_WIDTH-1:0][LW-1:0]     dispatchLatency,
    input  logic [ISSUE_QUEUE_ENTRY_NUM-1:0]      opReady,
    output logic [ISSUE_WIDTH-1:0]                issueValid,
    output logic [ISSUE_WIDTH-1:0][IDXW-1:0]      issuePtr,
    output logic                                  wakeup,
    output logic [ISSUE_QUEUE_ENTRY_NUM-1:0]      wakeupDstVector,
    output logic [ISSUE_QUEUE_ENTRY_NUM-1:0]      releaseVector,
    output logic [OCCW-1:0]                       occupancy
);

    localparam int unsigned N = ISSUE_QUEUE_ENTRY_NUM;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2
    } ent_state_e;

    // In WAIT, cnt holds the stored latency; in ISSUED it counts down to release.
    ent_state_e                         state_q [N];
    ent_state_e                         state_d [N];
    logic [LW-1:0]                      cnt_q   [N];
    logic [LW-1:0]                      cnt_d   [N];
    logic [IDXW-1:0]                    rr_q, rr_d;
    logic [ISSUE_WIDTH-1:0]             issueValid_q, issueValid_d;
    logic [ISSUE_WIDTH-1:0][IDXW-1:0]   issuePtr_q, issuePtr_d;
    logic [OCCW-1:0]                    occupancy_q, occupancy_d;

    logic [N-1:0]                       wake_c;
    logic [N-1:0]                       nonempty_c;
    logic [N-1:0]                       cand_c;
    logic [N-1:0]                       grant_vec_c;
    logic [ISSUE_WIDTH-1:0]             grant_vld_c;
    logic [ISSUE_WIDTH-1:0][IDXW-1:0]   grant_ptr_c;
    logic                               disp_en_c;
    logic                               disp_err_c;

    // (base + off) mod N without relying on N being a power of two
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                 input int unsigned off);
        logic [IDXW:0] s;
        s = {1'b0, base} + (IDXW+1)'(off);
        if (s >= (IDXW+1)'(N)) s = s - (IDXW+1)'(N);
        return s[IDXW-1:0];
    endfunction

    // Latency 0 is treated as 1; anything beyond MAX_LATENCY saturates.
    function automatic logic [LW-1:0] sat_lat(input logic [LW-1:0] lat);
        if (lat == '0)                  return LW'(1);
        else if (lat > LW'(MAX_LATENCY)) return LW'(MAX_LATENCY);
        else                            return lat;
    endfunction

    assign disp_en_c = !stall && !flush;

    // Per-entry status: wakeup at cnt==1, occupancy mask, select candidates
    always_comb begin
        wake_c     = '0;
        nonempty_c = '0;
        cand_c     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            wake_c[i]     = (state_q[i] == ST_ISSUED) && (cnt_q[i] == LW'(1));
            nonempty_c[i] = (state_q[i] != ST_EMPTY);
            cand_c[i]     = disp_en_c && (state_q[i] == ST_WAIT) && opReady[i];
        end
    end

    // Matrix ignores wakeups under stall, so the vector holds until a free edge;
    // flush suppresses wakeups and releases every occupied entry.
    assign wakeupDstVector = flush ? '0 : wake_c;
    assign releaseVector   = flush ? nonempty_c : (stall ? '0 : wake_c);
    assign wakeup          = |wakeupDstVector;

    // Round-robin select: scan from rrPtr, lane 0 takes the first candidate
    always_comb begin
        logic [N-1:0] rot;
        logic         found;
        grant_vld_c = '0;
        grant_ptr_c = '0;
        grant_vec_c = '0;
        rr_d        = rr_q;
        rot         = '0;
        found       = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            rot[k] = cand_c[wrap_add(rr_q, k)];
        end
        for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
            found = 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                if (!found && rot[k]) begin
                    found          = 1'b1;
                    rot[k]         = 1'b0;
                    grant_ptr_c[l] = wrap_add(rr_q, k);
                end
            end
            grant_vld_c[l] = found;
            if (found) rr_d = wrap_add(grant_ptr_c[l], 1);
        end
        for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
            if (grant_vld_c[l]) grant_vec_c[grant_ptr_c[l]] = 1'b1;
        end
    end

    // Entry next state: countdown/release, grant, dispatch (higher lane last), flush
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!stall) begin
                if (state_q[i] == ST_ISSUED) begin
                    if (cnt_q[i] > LW'(1)) begin
                        cnt_d[i] = cnt_q[i] - LW'(1);
                    end else begin
                        state_d[i] = ST_EMPTY;
                        cnt_d[i]   = '0;
                    end
                end else if ((state_q[i] == ST_WAIT) && grant_vec_c[i]) begin
                    state_d[i] = ST_ISSUED;
                end
            end
            if (disp_en_c) begin
                for (int unsigned d = 0; d < DISPATCH_WIDTH; d++) begin
                    if (dispatch[d] && (dispatchPtr[d] == IDXW'(i))) begin
                        state_d[i] = ST_WAIT;
                        cnt_d[i]   = sat_lat(dispatchLatency[d]);
                    end
                end
            end
            if (flush) begin
                state_d[i] = ST_EMPTY;
                cnt_d[i]   = '0;
            end
        end
    end

    // Registered issue outputs and occupancy from next state
    always_comb begin
        issueValid_d = grant_vld_c;
        issuePtr_d   = grant_ptr_c;
        occupancy_d  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            occupancy_d = occupancy_d + OCCW'(state_d[i] != ST_EMPTY);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i] <= ST_EMPTY;
                cnt_q[i]   <= '0;
            end
            rr_q         <= '0;
            issueValid_q <= '0;
            issuePtr_q   <= '0;
            occupancy_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rr_q         <= rr_d;
            issueValid_q <= issueValid_d;
            issuePtr_q   <= issuePtr_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign issueValid = issueValid_q;
    assign issuePtr   = issuePtr_q;
    assign occupancy  = occupancy_q;

    // Dispatch into an occupied entry (not being released this cycle) is a protocol error
    always_comb begin
        disp_err_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned d = 0; d < DISPATCH_WIDTH; d++) begin
                if (disp_en_c && dispatch[d] && (dispatchPtr[d] == IDXW'(i)) &&
                    nonempty_c[i] && !releaseVector[i]) begin
                    disp_err_c = 1'b1;
                end
            end
        end
    end

    a_no_dispatch_overwrite: assert property (@(posedge clk) disable iff (rst) !disp_err_c)
        else $error("dispatch into occupied issue queue entry");

endmodule

// File: doc/issue_queue_select_scheduler.md
Name: issue_queue_select_scheduler

Overview:
- Sequences the issue queue around the producer dependency matrix.
- Tracks per-entry lifecycle (empty, waiting, issued), selects up to ISSUE_WIDTH ready entries per cycle with round-robin priority, and times each issued entry's execution latency.
- Emits the wakeup/clear vector back to the dependency matrix at the right cycle, then releases the entry.
- Sits between dispatch, the dependency matrix's opReady outputs and the issue/register-read stage.

Parameters:
ISSUE_QUEUE_ENTRY_NUM, 16, number of issue queue entries (N)
DISPATCH_WIDTH, 2, dispatch lanes per cycle
ISSUE_WIDTH, 2, maximum grants per cycle
MAX_LATENCY, 4, largest execution latency in cycles; LW = clog2(MAX_LATENCY+1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous and active-high
stall  in  1  freeze all state (select, counters, dispatch)
flush  in  1  synchronous squash of all entries
dispatch  in  DISPATCH_WIDTH  per-lane dispatch valid
dispatchPtr  in  DISPATCH_WIDTH x clog2(N)  target entry per lane
dispatchLatency  in  DISPATCH_WIDTH x LW  execution latency per lane
opReady  in  N  per-entry operands ready, from the dependency matrix
issueValid  out  ISSUE_WIDTH  registered grant valid per lane
issuePtr  out  ISSUE_WIDTH x clog2(N)  registered granted entry per lane
wakeup  out  1  any wakeup bit asserted this cycle
wakeupDstVector  out  N  one-hot-per-entry producer clear vector (may be multi-hot)
releaseVector  out  N  entries returning to EMPTY at the next edge (equals wakeupDstVector unless overridden)
occupancy  out  clog2(N+1)  count of non-EMPTY entries (registered)

Behaviour:
- Per-entry state: EMPTY, WAIT, ISSUED. ISSUED carries a down-counter cnt[LW].
- Reset (async): all entries EMPTY, cnt=0, rrPtr=0. issueValid=0, issuePtr=0, wakeup=0, wakeupDstVector=0, releaseVector=0, occupancy=0.
- Dispatch, when not stall and not flush:
  - dispatch[d] puts entry dispatchPtr[d] into WAIT.
  - Latency is stored; dispatchLatency 0 is stored as 1; values above MAX_LATENCY saturate to MAX_LATENCY.
  - Dispatching into a non-EMPTY entry overwrites it; this is a protocol error flagged by an assertion.
  - Two lanes targeting the same entry: higher lane wins.
- Candidates: state==WAIT && opReady[i], evaluated only when not stall.
- Select: scan indices rrPtr, rrPtr+1, ... mod N and grant the first ISSUE_WIDTH candidates in scan order. Lane 0 gets the first grant.
  - rrPtr becomes (last granted index + 1) mod N.
  - rrPtr is unchanged when nothing is granted or during stall.
- Grant at edge T: entry goes WAIT→ISSUED with cnt=latency; issueValid/issuePtr are registered and visible in cycle T+1.
- Ungranted lanes drive issueValid=0 and issuePtr=0.
- Outputs are combinational from registers: wakeupDstVector[i] = (state==ISSUED && cnt==1); wakeup = |wakeupDstVector.
  - Latency 1: wakeup coincides with issueValid in T+1.
  - Latency L: wakeup in T+L.
- Each non-stalled edge, for every ISSUED entry:
  - cnt>1: decrement.
  - cnt==1: entry goes EMPTY (released).
- Stall:
  - All state, counters and rrPtr hold.
  - wakeupDstVector stays asserted until the first non-stalled cycle, because the matrix ignores wakeups under stall.
  - No grants are made; issueValid at the next edge is 0.
- Flush:
  - All entries EMPTY; issueValid cleared at the next edge; rrPtr kept.
  - Overrides dispatch and grant in the same cycle.
  - releaseVector = all entries currently non-EMPTY.
  - wakeupDstVector is forced to 0 in the flush cycle.
- Release and dispatch to the same entry in the same cycle: dispatch wins and the entry ends in WAIT with the new latency.
- occupancy is recomputed from next-state each edge. It is never above N and never underflows.
- Only WAIT entries are candidates, so an entry is never granted twice.

Test Plan:
- Reset mid-operation with 3 entries ISSUED → all outputs 0 asynchronously; occupancy=0 after release of rst.
- Dispatch entry 5 (lat 1) and entry 9 (lat 3), opReady all 1 at T → T+1: issueValid=11, issuePtr={5,9}, wakeupDstVector=bit5. T+3: bit9. occupancy 2→1→0.
- Entries 0,1,2,3 all ready, rrPtr=0, ISSUE_WIDTH=2 → grants {0,1}, then {2,3} the next cycle (rrPtr=2), then rrPtr=4.
- rrPtr=14 with entries 15 and 1 ready → grants {15,1}; rrPtr wraps to 2.
- Entry 7 at cnt==1 and stall held 3 cycles → wakeupDstVector bit7 held for 4 cycles; no issue; entry 7 EMPTY after stall drops.
- Flush with dispatch to entry 4 in the same cycle and 6 entries occupied → releaseVector has the 6 bits; next cycle occupancy=0, entry 4 EMPTY, issueValid=0.
